// File: rtl/rotational_cordic.sv
// rotational_cordic
//   Iterative rotation-mode CORDIC, one micro-rotation per clock.
//   Rotates (Xo, Yo) by Zo radians and returns the gain-compensated
//   result plus the residual angle. All words are signed Q6.12.
//
// Ports
//   CLK     rising-edge clock
//   RST     asynchronous active-low reset
//   ENABLE  start pulse, sampled in IDLE only
//   Xo/Yo   input vector
//   Zo      rotation angle (|Zo| <= pi/2)
//   XN/YN   rotated, gain-compensated vector (held until next completion)
//   ZN      residual angle after the last micro-rotation
//   Done    one-cycle pulse when XN/YN/ZN are updated
module rotational_cordic #(
    parameter int WORD_LENGTH = 18,
    parameter int ITERATIONS  = 12,
    parameter int FRAC_BITS   = 12
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   ENABLE,
    input  logic [WORD_LENGTH-1:0] Xo,
    input  logic [WORD_LENGTH-1:0] Yo,
    input  logic [WORD_LENGTH-1:0] Zo,
    output logic [WORD_LENGTH-1:0] XN,
    output logic [WORD_LENGTH-1:0] YN,
    output logic [WORD_LENGTH-1:0] ZN,
    output logic                   Done
);

    localparam int IW = $clog2(ITERATIONS);
    localparam int PW = WORD_LENGTH + FRAC_BITS;
    localparam logic [IW-1:0] LAST_IT = IW'(ITERATIONS - 1);
    // 1/1.646760 in Q6.12, cancels the accumulated micro-rotation gain
    localparam logic signed [WORD_LENGTH-1:0] K = WORD_LENGTH'(2487);

    typedef enum logic [1:0] {S_IDLE, S_ROTATE, S_SCALE} state_t;

    // atan(2^-i) in Q6.12, rounded to nearest
    function automatic logic signed [WORD_LENGTH-1:0] atan_lut(input logic [IW-1:0] idx);
        case (idx)
            IW'(0):  atan_lut = WORD_LENGTH'(3217);
            IW'(1):  atan_lut = WORD_LENGTH'(1899);
            IW'(2):  atan_lut = WORD_LENGTH'(1003);
            IW'(3):  atan_lut = WORD_LENGTH'(509);
            IW'(4):  atan_lut = WORD_LENGTH'(256);
            IW'(5):  atan_lut = WORD_LENGTH'(128);
            IW'(6):  atan_lut = WORD_LENGTH'(64);
            IW'(7):  atan_lut = WORD_LENGTH'(32);
            IW'(8):  atan_lut = WORD_LENGTH'(16);
            IW'(9):  atan_lut = WORD_LENGTH'(8);
            IW'(10): atan_lut = WORD_LENGTH'(4);
            IW'(11): atan_lut = WORD_LENGTH'(2);
            default: atan_lut = '0;
        endcase
    endfunction

    state_t                        r_state;
    logic signed [WORD_LENGTH-1:0] r_x, r_y, r_z;
    logic [IW-1:0]                 r_i;

    logic signed [WORD_LENGTH-1:0] w_xsh, w_ysh, w_atan;
    logic signed [PW-1:0]          w_px, w_py;

    assign w_xsh  = r_x >>> r_i;
    assign w_ysh  = r_y >>> r_i;
    assign w_atan = atan_lut(r_i);

    // Only the low PW bits of the full product are ever kept, so a PW-wide
    // multiply is bit-identical to the full-width one for the bits we use.
    assign w_px = PW'(r_x) * PW'(K);
    assign w_py = PW'(r_y) * PW'(K);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= S_IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
            r_i     <= '0;
            XN      <= '0;
            YN      <= '0;
            ZN      <= '0;
            Done    <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (ENABLE) begin
                        r_x     <= Xo;
                        r_y     <= Yo;
                        r_z     <= Zo;
                        r_i     <= '0;
                        r_state <= S_ROTATE;
                    end
                end
                S_ROTATE: begin
                    // z sign picks the rotation direction that drives z to 0
                    if (!r_z[WORD_LENGTH-1]) begin
                        r_x <= r_x - w_ysh;
                        r_y <= r_y + w_xsh;
                        r_z <= r_z - w_atan;
                    end else begin
                        r_x <= r_x + w_ysh;
                        r_y <= r_y - w_xsh;
                        r_z <= r_z + w_atan;
                    end
                    if (r_i == LAST_IT) begin
                        r_state <= S_SCALE;
                    end else begin
                        r_i <= r_i + IW'(1);
                    end
                end
                S_SCALE: begin
                    XN      <= w_px[PW-1:FRAC_BITS];
                    YN      <= w_py[PW-1:FRAC_BITS];
                    ZN      <= r_z;
                    Done    <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rotational_cordic.sv
module tb_rotational_cordic;

    localparam int WL = 18;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          ENABLE = 1'b0;
    logic [WL-1:0] Xo = '0, Yo = '0, Zo = '0;
    logic [WL-1:0] XN, YN, ZN;
    logic          Done;

    int checks = 0;
    int errors = 0;
    int last_zn = 0;

    rotational_cordic #(.WORD_LENGTH(WL), .ITERATIONS(12), .FRAC_BITS(12)) dut (
        .CLK(CLK), .RST(RST), .ENABLE(ENABLE),
        .Xo(Xo), .Yo(Yo), .Zo(Zo),
        .XN(XN), .YN(YN), .ZN(ZN), .Done(Done)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input int obs, input int exp, input int tol);
        int d;
        checks++;
        d = obs - exp;
        if (d < 0) d = -d;
        if (d > tol) begin
            errors++;
            $display("FAIL %s got %0d want %0d (tol %0d)", tag, obs, exp, tol);
        end
    endtask

    function automatic int sx(input logic [WL-1:0] v);
        return {{(32-WL){v[WL-1]}}, v};
    endfunction

    // Reference: the z recursion fixes the direction sequence; the vector is
    // then rotated by the exact angle those directions represent, scaled by
    // the true CORDIC gain times K. ZN is exact; XN/YN carry a tolerance for
    // shift truncation.
    function automatic void model(input int x, input int y, input int z,
                                  output int xe, output int ye, output int ze);
        int    tab [12] = '{3217, 1899, 1003, 509, 256, 128, 64, 32, 16, 8, 4, 2};
        real   th, g, xr, yr, s;
        int    zz;
        zz = z;
        th = 0.0;
        g  = 1.0;
        for (int i = 0; i < 12; i++) begin
            s = $pow(2.0, -1.0 * i);
            g = g * $sqrt(1.0 + s * s);
            if (zz >= 0) begin
                th += $atan(s);
                zz -= tab[i];
            end else begin
                th -= $atan(s);
                zz += tab[i];
            end
        end
        g  = g * 2487.0 / 4096.0;
        xr = real'(x);
        yr = real'(y);
        xe = int'(g * (xr * $cos(th) - yr * $sin(th)));
        ye = int'(g * (yr * $cos(th) + xr * $sin(th)));
        ze = zz;
    endfunction

    // Starts one operation on the next edge and waits for Done.
    // busy_en: pulse ENABLE (with other operands) in the middle of ROTATE.
    task automatic run_op(input int x, input int y, input int z, input bit busy_en);
        int xe, ye, ze, n;
        model(x, y, z, xe, ye, ze);
        Xo = x[WL-1:0];
        Yo = y[WL-1:0];
        Zo = z[WL-1:0];
        ENABLE = 1'b1;
        @(posedge CLK); #1;
        ENABLE = 1'b0;
        Xo = WL'($urandom);
        Yo = WL'($urandom);
        Zo = WL'($urandom);
        chk("done_low_at_start", int'(Done), 0, 0);
        n = 0;
        while (n < 20) begin
            @(posedge CLK); #1;
            n++;
            if (Done) break;
            if (n == 6) chk("zn_hold", sx(ZN), last_zn, 0);
            if (busy_en && n == 4) begin
                Xo = 18'h01000; Yo = 18'h01000; Zo = 18'h00800;
                ENABLE = 1'b1;
            end else begin
                ENABLE = 1'b0;
            end
        end
        ENABLE = 1'b0;
        chk("latency", n, 13, 0);
        chk("xn", sx(XN), xe, 8);
        chk("yn", sx(YN), ye, 8);
        chk("zn", sx(ZN), ze, 0);
        last_zn = ze;
    endtask

    task automatic count_dones(input int cycles, output int cnt);
        cnt = 0;
        repeat (cycles) begin
            @(posedge CLK); #1;
            if (Done) cnt++;
        end
    endtask

    initial begin
        int cnt, x, y, z;

        // reset state
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_xn", sx(XN), 0, 0);
        chk("rst_yn", sx(YN), 0, 0);
        chk("rst_zn", sx(ZN), 0, 0);
        chk("rst_done", int'(Done), 0, 0);
        RST = 1'b1;
        count_dones(6, cnt);
        chk("idle_no_done", cnt, 0, 0);
        chk("idle_xn", sx(XN), 0, 0);

        // directed vectors
        run_op(4096, 8192, 6433, 0);
        chk("pi2_xn_ideal", sx(XN), -8192, 8);
        chk("pi2_yn_ideal", sx(YN), 4096, 8);
        @(posedge CLK); #1;
        chk("done_one_cycle", int'(Done), 0, 0);

        run_op(3*4096, 4*4096, -6434, 0);
        chk("m_xn_ideal", sx(XN), 4*4096, 8);
        chk("m_yn_ideal", sx(YN), -3*4096, 8);
        run_op(-3*4096, 4*4096, -6434, 0);
        chk("q2_xn_ideal", sx(XN), 4*4096, 8);
        chk("q2_yn_ideal", sx(YN), 3*4096, 8);
        run_op(3*4096, -4*4096, -6434, 0);
        chk("q4_xn_ideal", sx(XN), -4*4096, 8);
        chk("q4_yn_ideal", sx(YN), -3*4096, 8);
        // back-to-back: issued right after the Done cycle
        run_op(-3*4096, -4*4096, 6433, 0);
        chk("q3_xn_ideal", sx(XN), 4*4096, 8);
        chk("q3_yn_ideal", sx(YN), -3*4096, 8);

        // ENABLE during ROTATE is ignored
        run_op(2*4096, 1*4096, 3000, 1);
        count_dones(20, cnt);
        chk("busy_en_ignored", cnt, 0, 0);

        // randomized operands, back-to-back
        for (int k = 0; k < 40; k++) begin
            x = int'($urandom_range(0, 2*24576)) - 24576;
            y = int'($urandom_range(0, 2*24576)) - 24576;
            z = int'($urandom_range(0, 2*6433)) - 6433;
            run_op(x, y, z, 0);
        end

        // reset in the middle of an operation
        Xo = 18'h01000; Yo = 18'h02000; Zo = 18'h01921;
        ENABLE = 1'b1;
        @(posedge CLK); #1;
        ENABLE = 1'b0;
        repeat (5) @(posedge CLK);
        #1;
        RST = 1'b0;
        #2;
        chk("midrst_xn", sx(XN), 0, 0);
        chk("midrst_yn", sx(YN), 0, 0);
        chk("midrst_zn", sx(ZN), 0, 0);
        chk("midrst_done", int'(Done), 0, 0);
        @(posedge CLK); #1;
        RST = 1'b1;
        last_zn = 0;
        count_dones(20, cnt);
        chk("midrst_no_done", cnt, 0, 0);
        chk("midrst_zn_kept", sx(ZN), 0, 0);
        run_op(4096, 8192, 6433, 0);
        chk("after_rst_xn", sx(XN), -8192, 8);
        chk("after_rst_yn", sx(YN), 4096, 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got 0 want 1");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/rotational_cordic.md
Name: rotational_cordic

Overview:
- Iterative, one-iteration-per-clock CORDIC in rotation mode. Rotates the vector (Xo, Yo) by angle Zo (radians) and returns gain-compensated XN = Xo·cos Zo − Yo·sin Zo and YN = Yo·cos Zo + Xo·sin Zo, plus the residual angle ZN (≈0).
- Used as a trig/rotation datapath engine, started by a one-cycle ENABLE pulse and reporting completion with a one-cycle Done pulse.

Parameters:
- WORD_LENGTH, 18: width of all data/angle words. Signed two's complement Q6.12: 6 integer bits including sign, 12 fractional bits. 1.0 = 0x01000.
- ITERATIONS, 12: number of micro-rotations.
- FRAC_BITS, 12: fractional bits of the fixed-point format.

Ports:
- CLK input 1: single clock, rising edge.
- RST input 1: asynchronous, active-low reset.
- ENABLE input 1: start pulse, sampled on the rising edge of CLK.
- Xo input WORD_LENGTH: initial x, Q6.12 signed.
- Yo input WORD_LENGTH: initial y, Q6.12 signed.
- Zo input WORD_LENGTH: rotation angle in radians, Q6.12 signed. Valid range |Zo| ≤ π/2 (0x01921 / 0x3E6DF).
- XN output WORD_LENGTH: rotated, gain-compensated x, Q6.12.
- YN output WORD_LENGTH: rotated, gain-compensated y, Q6.12.
- ZN output WORD_LENGTH: residual angle after the final iteration.
- Done output 1: one-cycle pulse when XN/YN/ZN are updated.

Behaviour:
- Reset (RST=0, asynchronous):
  - State goes to IDLE.
  - XN, YN, ZN, Done, internal x/y/z and the iteration counter all clear to 0.
  - A reset asserted mid-operation aborts the computation; no Done is produced.
- States:
  - IDLE: on a rising edge with ENABLE=1, latch Xo/Yo/Zo into x/y/z, clear counter i=0, go to ROTATE.
  - ROTATE: one iteration per clock for i = 0 … ITERATIONS−1.
    - If z ≥ 0 (sign bit 0): x ← x − (y>>>i); y ← y + (x>>>i); z ← z − atan_i.
    - Otherwise: x ← x + (y>>>i); y ← y − (x>>>i); z ← z + atan_i.
    - Shifts are arithmetic. Updates are simultaneous, using pre-update values.
    - After the iteration with i = ITERATIONS−1, go to SCALE.
  - SCALE:
    - XN ← (x · K) >>> 12 and YN ← (y · K) >>> 12, with K = 0x009B7 (2487 ≈ 0.607253).
    - Use a full-width signed product, truncated, keeping the low WORD_LENGTH bits.
    - ZN ← z.
    - Done = 1 for this cycle only; return to IDLE.
- atan table (Q6.12, rounded to nearest), i = 0 … 11: 3217, 1899, 1003, 509, 256, 128, 64, 32, 16, 8, 4, 2.
- Latency:
  - ENABLE sampled at edge k.
  - Iterations at edges k+1 … k+12.
  - Outputs registered and Done high after edge k+13; Done deasserts after edge k+14.
- ENABLE while busy (ROTATE/SCALE) is ignored. Inputs need only be valid on the ENABLE edge.
- XN/YN/ZN hold their last result until the next completion. They are not disturbed during a computation.
- Done is 0 at all other times. A new ENABLE is accepted in the cycle after Done, once the block is back in IDLE.
- Internal arithmetic is WORD_LENGTH wide with wrap-around; no saturation.
  - The caller keeps |x|,|y| magnitudes ≤ 12, so the 1.647 internal gain fits in range.
- Accuracy: XN/YN within ±8 LSB of the ideal result; |ZN| ≤ 4 LSB.

Test Plan:
- Reset: hold RST=0 → XN=YN=ZN=0, Done=0. Release; with no ENABLE, outputs stay 0 and Done stays 0.
- Xo=0x01000 (1), Yo=0x02000 (2), Zo=0x01921 (π/2), one-cycle ENABLE:
  - Done pulses exactly 13 cycles after the ENABLE edge, for exactly 1 cycle.
  - XN ≈ 0x3E000 (−2), YN ≈ 0x01000 (1), ZN ≈ 0, within tolerance.
- Xo=3, Yo=4, Zo=0x3E6DE (−π/2) → XN ≈ 4 (0x04000), YN ≈ −3 (0x3D000).
- Xo=−3 (0x3D000), Yo=4, Zo=−π/2 → XN ≈ 4, YN ≈ 3. Then Xo=3, Yo=−4 (0x3C000), Zo=−π/2 → XN ≈ −4, YN ≈ −3.
- Xo=−3, Yo=−4, Zo=π/2 → XN ≈ 4, YN ≈ −3.
  - Back-to-back starts: an ENABLE in the cycle after Done is accepted.
  - An ENABLE pulse during ROTATE is ignored: a single Done occurs, with the result of the first operands.
- Mid-operation reset: assert RST=0 at iteration 5 → outputs clear immediately and no Done follows. A subsequent ENABLE computes correctly.
